// File: rtl/cache_controller.sv
// cache_controller
//   Sequences the 2-way, 64-set, 64-bit-line data cache and the SRAM controller
//   on behalf of the MEM stage. Read hits complete with no wait, read misses
//   fetch a line from SRAM, fill the cache and forward the requested word.
//   Stores are write-through, no-allocate: the matching line is invalidated and
//   the word goes straight to SRAM. ready=0 freezes the pipeline.
//
//   state   | meaning
//   IDLE    | free; serves hits, accepts new requests
//   RD_MISS | waiting for an SRAM line read, fills the cache on completion
//   WR_SRAM | waiting for an SRAM word write
//
// Ports
//   clk, rst                          clock, async active-low reset
//   address, wdata, MEM_R_EN/MEM_W_EN MEM-stage request
//   rdata, ready                      load data / completion
//   cache_addr, cache_R_EN/W_EN,
//   cache_wdata, invalidate           cache control
//   hit, cache_rdata                  cache response
//   sram_address, sram_wdata,
//   sram_R_EN, sram_W_EN              SRAM controller request
//   sram_rdata, sram_ready            SRAM controller response
module cache_controller #(
  parameter int unsigned BASE_ADDR = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [18:0] cache_addr,
  output logic        cache_R_EN,
  output logic        cache_W_EN,
  output logic [63:0] cache_wdata,
  output logic        invalidate,
  input  logic        hit,
  input  logic [31:0] cache_rdata,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  output logic        sram_R_EN,
  output logic        sram_W_EN,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready
);

  localparam logic [18:0] LP_BASE = 19'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_SRAM} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_req_addr;
  logic [31:0] r_req_wdata;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;

  // IDLE forwards the live request; busy states only use the latched copy.
  assign w_addr  = (r_state == IDLE) ? address : r_req_addr;
  assign w_wdata = (r_state == IDLE) ? wdata   : r_req_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next != IDLE) begin
        r_req_addr  <= address;
        r_req_wdata <= wdata;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    rdata        = '0;
    ready        = 1'b1;
    cache_R_EN   = 1'b0;
    cache_W_EN   = 1'b0;
    cache_wdata  = '0;
    invalidate   = 1'b0;
    sram_R_EN    = 1'b0;
    sram_W_EN    = 1'b0;
    cache_addr   = w_addr[18:0] - LP_BASE;
    sram_address = w_addr;
    sram_wdata   = w_wdata;

    // While reset is asserted everything is quiet, including the address buses
    // that would otherwise follow the live MEM-stage inputs.
    if (!rst) begin
      w_next       = IDLE;
      cache_addr   = '0;
      sram_address = '0;
      sram_wdata   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (MEM_W_EN) begin
            // store wins over a simultaneous load
            invalidate = 1'b1;
            ready      = 1'b0;
            w_next     = WR_SRAM;
          end else if (MEM_R_EN) begin
            cache_R_EN = 1'b1;
            if (hit) begin
              rdata = cache_rdata;
            end else begin
              ready  = 1'b0;
              w_next = RD_MISS;
            end
          end
        end
        RD_MISS: begin
          if (sram_ready) begin
            cache_W_EN  = 1'b1;
            cache_wdata = sram_rdata;
            rdata       = r_req_addr[2] ? sram_rdata[63:32] : sram_rdata[31:0];
            w_next      = IDLE;
          end else begin
            sram_R_EN = 1'b1;
            ready     = 1'b0;
          end
        end
        WR_SRAM: begin
          if (sram_ready) begin
            w_next = IDLE;
          end else begin
            sram_W_EN = 1'b1;
            ready     = 1'b0;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;
  localparam int LAT = 6;

  logic        clk;
  logic        rst;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] rdata;
  logic        ready;
  logic [18:0] cache_addr;
  logic        cache_R_EN;
  logic        cache_W_EN;
  logic [63:0] cache_wdata;
  logic        invalidate;
  logic        hit;
  logic [31:0] cache_rdata;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic        sram_R_EN;
  logic        sram_W_EN;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  cache_controller #(.BASE_ADDR(1024)) dut (
    .clk(clk), .rst(rst), .address(address), .wdata(wdata),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .rdata(rdata), .ready(ready),
    .cache_addr(cache_addr), .cache_R_EN(cache_R_EN), .cache_W_EN(cache_W_EN),
    .cache_wdata(cache_wdata), .invalidate(invalidate), .hit(hit),
    .cache_rdata(cache_rdata), .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_R_EN(sram_R_EN), .sram_W_EN(sram_W_EN), .sram_rdata(sram_rdata),
    .sram_ready(sram_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- cache model (direct-mapped is enough here) -------------
  bit          cv [65536];
  logic [63:0] cl [65536];
  logic [15:0] idx;
  assign idx         = cache_addr[18:3];
  assign hit         = cv[idx];
  assign cache_rdata = cache_addr[2] ? cl[idx][63:32] : cl[idx][31:0];

  always @(posedge clk) begin
    if (cache_W_EN) begin
      cv[idx] <= 1'b1;
      cl[idx] <= cache_wdata;
    end else if (invalidate) begin
      cv[idx] <= 1'b0;
    end
  end

  // ---------------- SRAM model ---------------------------------------------
  logic [63:0] smem [logic [28:0]];
  logic [63:0] ln;
  int          scnt;

  function automatic logic [63:0] line_of(input logic [31:0] a);
    logic [28:0] k;
    logic [31:0] b;
    k = a[31:3];
    b = {a[31:3], 3'b000};
    if (smem.exists(k)) return smem[k];
    if (k == 29'h81) return 64'hAAAA_BBBB_1111_2222;
    return {32'hC0DE_0000 ^ b, 32'h5A5A_0000 ^ b};
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [63:0] l;
    l = line_of(a);
    return a[2] ? l[63:32] : l[31:0];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      scnt       <= 0;
      sram_ready <= 1'b0;
      sram_rdata <= '0;
    end else begin
      sram_ready <= 1'b0;
      if ((sram_R_EN || sram_W_EN) && !sram_ready) begin
        if (scnt == LAT - 1) begin
          scnt       <= 0;
          sram_ready <= 1'b1;
          if (sram_R_EN) begin
            sram_rdata <= line_of(sram_address);
          end else begin
            ln = line_of(sram_address);
            if (sram_address[2]) ln[63:32] = sram_wdata;
            else                 ln[31:0]  = sram_wdata;
            smem[sram_address[31:3]] = ln;
          end
        end else begin
          scnt <= scnt + 1;
        end
      end
    end
  end

  // ---------------- checking -----------------------------------------------
  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int c_wait, c_ren, c_wen, c_inv, c_cwen, c_cren, c_excl;

  // Drives one request at a negedge, samples every cycle until ready, then
  // releases the request at the following negedge.
  task automatic run_req(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic r, input logic w);
    bit          done;
    logic [31:0] e;
    logic [18:0] ca;
    done   = 0;
    c_wait = 0; c_ren = 0; c_wen = 0; c_inv = 0; c_cwen = 0; c_cren = 0; c_excl = 0;
    ca     = a[18:0] - 19'd1024;
    if (r && !w) exp_q.push_back(rd_word(a));
    address  = a;
    wdata    = d;
    MEM_R_EN = r;
    MEM_W_EN = w;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      c_ren  += int'(sram_R_EN);
      c_wen  += int'(sram_W_EN);
      c_inv  += int'(invalidate);
      c_cwen += int'(cache_W_EN);
      c_cren += int'(cache_R_EN);
      if ((int'(cache_R_EN) + int'(cache_W_EN) + int'(invalidate) > 1) || (sram_R_EN && sram_W_EN))
        c_excl++;
      if (ready) begin
        done = 1;
        chk({tag, "_caddr"}, cache_addr, ca);
        chk({tag, "_saddr"}, sram_address, a);
        if (w) chk({tag, "_swdata"}, sram_wdata, d);
        if (r && !w) begin
          if (exp_q.size() == 0) chk({tag, "_sb_underflow"}, 1, 0);
          else begin
            e = exp_q.pop_front();
            chk({tag, "_rdata"}, rdata, e);
          end
        end
      end else begin
        c_wait++;
      end
      @(negedge clk);
    end
    if (!done) chk({tag, "_timeout"}, 0, 1);
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    chk({tag, "_excl"}, c_excl, 0);
  endtask

  int  n;
  bit  seen;

  initial begin
    rst      = 1'b0;
    address  = 32'h0000_0408;
    wdata    = 32'h1234_5678;
    MEM_R_EN = 1'b1;
    MEM_W_EN = 1'b0;
    #12;
    chk("rst_ready", ready, 1);
    chk("rst_en", {cache_R_EN, cache_W_EN, invalidate, sram_R_EN, sram_W_EN}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_addr", {cache_addr, sram_address, sram_wdata}, 0);
    MEM_R_EN = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 1: cold miss
    run_req("t1", 32'h0000_0408, 0, 1, 0);
    chk("t1_wait", c_wait, 1 + LAT);
    chk("t1_ren", c_ren, LAT);
    chk("t1_cwen", c_cwen, 1);
    chk("t1_cren", c_cren, 1);

    // 2: hit on the just-filled line, next cycle
    run_req("t2", 32'h0000_040C, 0, 1, 0);
    chk("t2_wait", c_wait, 0);
    chk("t2_ren", c_ren, 0);

    // 3: store, then reload misses
    run_req("t3", 32'h0000_0408, 32'hDEAD_BEEF, 0, 1);
    chk("t3_inv", c_inv, 1);
    chk("t3_wen", c_wen, LAT);
    chk("t3_wait", c_wait, 1 + LAT);
    chk("t3_cwen", c_cwen, 0);
    run_req("t3_ld", 32'h0000_0408, 0, 1, 0);
    chk("t3_ld_ren", c_ren, LAT);

    // 4: load and store together -> store path
    run_req("t4", 32'h0000_0410, 32'h1234_5678, 1, 1);
    chk("t4_inv", c_inv, 1);
    chk("t4_wen", c_wen, LAT);
    chk("t4_ren", c_ren, 0);
    run_req("t4_ld", 32'h0000_0410, 0, 1, 0);
    chk("t4_ld_ren", c_ren, LAT);

    // 5: load miss withdrawn after two cycles
    address  = 32'h0000_0500;
    MEM_R_EN = 1'b1;
    repeat (2) @(negedge clk);
    MEM_R_EN = 1'b0;
    n    = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      #1;
      if (sram_R_EN) n++;
      if (cache_W_EN) begin
        seen = 1;
        chk("t5_ready", ready, 1);
      end
      @(negedge clk);
    end
    chk("t5_fill", seen, 1);
    chk("t5_ren", n, LAT - 1);
    #1;
    chk("t5_idle", {ready, sram_R_EN}, 2'b10);
    @(negedge clk);
    run_req("t5_hit", 32'h0000_0500, 0, 1, 0);
    chk("t5_hit_wait", c_wait, 0);

    // 6: reset during RD_MISS
    address  = 32'h0000_0600;
    MEM_R_EN = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("t6_pre", sram_R_EN, 1);
    rst      = 1'b0;
    MEM_R_EN = 1'b0;
    #1;
    chk("t6_ready", ready, 1);
    chk("t6_en", {sram_R_EN, sram_W_EN, cache_W_EN}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_req("t6_hit", 32'h0000_0408, 0, 1, 0);
    chk("t6_hit_wait", c_wait, 0);
    chk("t6_hit_ren", c_ren, 0);

    chk("sb_left", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
